packet_queue_ctrl: RTL
======================

// Module: packet_queue_ctrl
// PURPOSE
//  Owns the packet buffer as a circular queue of fixed-size slots for the transmit path.
//  The UART RX byte stream is written into the tail slot; completed slots are handed one at a time to the
//  stream_from_memory/eth_tx chain via a start/done handshake.
//  Replaces the ad-hoc head/tail logic in the top level; drops whole packets on overflow.
// PARAMETERS
//  SLOT_LEN   1000  bytes per packet (FGP_LEN); a packet is complete after SLOT_LEN bytes
//  SLOT_BITS  10    clog2(SLOT_LEN); slot stride in RAM = 2**SLOT_BITS
//  NUM_SLOTS  8     slots in buffer; power of two; usable capacity NUM_SLOTS-1
//  Q_BITS     3     clog2(NUM_SLOTS); RAM address width = Q_BITS+SLOT_BITS
// PORTS
//  clk            in   1        system clock (50MHz)
//  rst            in   1        asynchronous active-high reset
//  flush          in   1        sync clear of pending/partial packets (e.g. UART RX inactivity)
//  inclk          in   1        input byte valid strobe
//  in             in   8        input byte
//  ram_we         out  1        packet buffer write enable
//  ram_waddr      out  Q+S      write address {tail, byte_cnt}
//  ram_win        out  8        write data
//  tx_start       out  1        one-cycle pulse: begin transmitting slot at tx_read_start
//  tx_read_start  out  Q+S      {head, SLOT_BITS'b0}, held stable from tx_start until tx_done
//  tx_read_end    out  Q+S+1    tx_read_start + SLOT_LEN
//  tx_done        in   1        downstream transmit finished (pulse)
//  tx_active      out  1        high from tx_start cycle until tx_done accepted
//  occupancy      out  Q_BITS   completed, not-yet-retired slots = tail - head (mod NUM_SLOTS)
//  overflow       out  1        one-cycle pulse: completed packet dropped (queue full)
// BEHAVIOUR
//  Reset: head=tail=byte_cnt=0, FSM=IDLE; all outputs 0 except tx_read_end=SLOT_LEN.
//  Write side (combinational, zero latency): ram_we=inclk & !rst, ram_waddr={tail,byte_cnt}, ram_win=in.
//  - byte_cnt++ per inclk; at byte_cnt==SLOT_LEN-1, byte_cnt<=0 and:
//    - if tail+1 != head (pre-update values), tail<=tail+1
//    - else tail held, overflow pulses next cycle; packet is overwritten by next packet
//  - Full slot is never the one being read, since capacity is NUM_SLOTS-1.
//  Read FSM:
//  - IDLE:   if head != tail -> START
//  - START:  tx_start=1 for exactly this cycle, tx_active=1 -> ACTIVE
//  - ACTIVE: tx_active=1; on tx_done: head<=head+1 (wraps mod NUM_SLOTS) -> IDLE
//  - tx_done is ignored in IDLE/START.
//  - Minimum spacing: 2 idle cycles between consecutive tx_start pulses (ACTIVE->IDLE->START).
//  - Simultaneous tail advance and head retire in one cycle: both apply; occupancy unchanged.
//  flush (synchronous, priority over inclk in same cycle; the flushed-cycle byte is not counted):
//  - byte_cnt<=0
//  - In IDLE: tail<=head; FSM unchanged.
//  - In START/ACTIVE: tail<=head+1; the in-flight slot completes normally, later slots discarded.
//  - overflow not asserted by flush.
//  Async rst mid-transmission: FSM to IDLE immediately; no tx_done expected; downstream also reset.
//  Arithmetic: pointers Q_BITS wide, wrap naturally; tx_read_end computed one bit wider (no wrap).
// TESTING
//  1) 1000 inclk bytes 0..999 -> ram_waddr 0x000..0x3E7; tx_start 2 cycles after last byte;
//     tx_read_start=0, tx_read_end=1000.
//  2) 3 packets back-to-back, tx_done 50 cycles after each start -> tx_start with read_start
//     0x000, 0x400, 0x800; occupancy 3->0; head=tail=3.
//  3) tx_done held low; write 8 packets -> 7 accepted (occupancy 7), 8th gives one overflow pulse; tail=7.
//  4) Head at 7, tail wraps 7->0 -> tx_read_start=0x1C00 then 0x0000; tx_read_end=0x1C00+1000.
//  5) flush during ACTIVE with 3 pending -> tail=head+1; tx_done -> occupancy 0, no further tx_start.
//  6) rst asserted mid-packet, async (no clk edge) -> tx_active=0, ram_we=0, occupancy=0 immediately.

Source files
------------

// File: rtl/packet_queue_ctrl.sv
// Circular packet buffer controller: fills the tail slot from the UART RX
// byte stream and hands completed slots to the transmit chain one at a time.
module packet_queue_ctrl #(
    parameter int SLOT_LEN  = 1000,
    parameter int SLOT_BITS = 10,
    parameter int NUM_SLOTS = 8,
    parameter int Q_BITS    = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        inclk,
    input  logic [7:0]                  in,
    output logic                        ram_we,
    output logic [Q_BITS+SLOT_BITS-1:0] ram_waddr,
    output logic [7:0]                  ram_win,
    output logic                        tx_start,
    output logic [Q_BITS+SLOT_BITS-1:0] tx_read_start,
    output logic [Q_BITS+SLOT_BITS:0]   tx_read_end,
    input  logic                        tx_done,
    output logic                        tx_active,
    output logic [Q_BITS-1:0]           occupancy,
    output logic                        overflow
);

    localparam int AW = Q_BITS + SLOT_BITS;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_START  = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;

    localparam logic [SLOT_BITS-1:0] LAST_BYTE  = SLOT_BITS'(SLOT_LEN - 1);
    localparam logic [AW:0]          SLOT_LEN_W = (AW + 1)'(SLOT_LEN);
    localparam logic [Q_BITS-1:0]    Q_ONE      = Q_BITS'(1);

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [Q_BITS-1:0]    head;
    logic [Q_BITS-1:0]    head_nxt;
    logic [Q_BITS-1:0]    tail;
    logic [Q_BITS-1:0]    tail_nxt;
    logic [SLOT_BITS-1:0] byte_cnt;
    logic [SLOT_BITS-1:0] byte_cnt_nxt;
    logic                 overflow_nxt;

    logic byte_acc;
    logic pkt_done;
    logic q_full;
    logic retire;
    logic busy;

    assign busy     = (state == S_START) || (state == S_ACTIVE);
    assign byte_acc = inclk & ~flush;
    assign pkt_done = byte_acc && (byte_cnt == LAST_BYTE);
    assign q_full   = (tail + Q_ONE) == head;
    assign retire   = (state == S_ACTIVE) && tx_done;

    // A flush in IDLE must not launch a slot that is being discarded.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if ((head != tail) && !flush) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (tx_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        head_nxt = head;
        if (retire) begin
            head_nxt = head + Q_ONE;
        end
    end

    // The in-flight slot survives a flush; everything queued behind it goes.
    always_comb begin
        tail_nxt     = tail;
        byte_cnt_nxt = byte_cnt;
        overflow_nxt = 1'b0;
        if (flush) begin
            byte_cnt_nxt = '0;
            tail_nxt     = busy ? (head + Q_ONE) : head;
        end else if (inclk) begin
            if (pkt_done) begin
                byte_cnt_nxt = '0;
                if (q_full) begin
                    overflow_nxt = 1'b1;
                end else begin
                    tail_nxt = tail + Q_ONE;
                end
            end else begin
                byte_cnt_nxt = byte_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            head     <= '0;
            tail     <= '0;
            byte_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            head     <= head_nxt;
            tail     <= tail_nxt;
            byte_cnt <= byte_cnt_nxt;
            overflow <= overflow_nxt;
        end
    end

    assign ram_we    = inclk & ~rst;
    assign ram_waddr = {tail, byte_cnt};
    assign ram_win   = in;

    assign tx_start      = (state == S_START);
    assign tx_active     = busy;
    assign tx_read_start = {head, {SLOT_BITS{1'b0}}};
    assign tx_read_end   = {1'b0, tx_read_start} + SLOT_LEN_W;
    assign occupancy     = tail - head;

endmodule
